sw_debounce: RTL and testbench

Input-side conditioner for the board slide switches and push-buttons. It is the reading end of the switch-to-LED path. Raw asynchronous switch pins enter the block, which synchronises and debounces them. It presents clean levels plus one-cycle rise/fall event pulses to downstream logic. It also drives a combined activity output, the OR of the debounced levels, for direct LED connection.

---
 rtl/sw_debounce_pkg.sv | 22 ++
 rtl/sw_debounce_ch.sv | 121 ++++++++++++
 rtl/sw_debounce.sv | 39 +++
 tb/tb_sw_debounce.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// sw_pkg: shared channel states, default timing and counter sizing helper
package sw_pkg;

    typedef enum logic [1:0] {
        ST_LO      = 2'b00,
        ST_WAIT_HI = 2'b01,
        ST_HI      = 2'b10,
        ST_WAIT_LO = 2'b11
    } sw_state_e;

    // 10 ms of stability at a 32 MHz system clock
    localparam int DEBOUNCE_CYCLES_32MHZ = 320000;

    // Smallest counter width w such that 2^w > cycles
    function automatic int min_cnt_w(input int cycles);
        int w;
        w = 1;
        while ((longint'(1) << w) <= longint'(cycles)) w++;
        return w;
    endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// sw_debounce_ch: one switch channel - 2-FF synchroniser, debounce FSM, edge pulses
module sw_debounce_ch
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_32MHZ,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_level,
    output logic sw_rise,
    output logic sw_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // A single matching sample is enough, so the waiting states are skipped
    localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

    logic             s1_q, s2_q;
    sw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sw_in;
            s2_q <= s1_q;
        end
    end

    // Next state: a new level is accepted only after DEBOUNCE_CYCLES matching samples of s2
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                if (s2_q) begin
                    if (SINGLE) begin
                        state_d = ST_HI;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (!s2_q) begin
                    state_d = ST_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HI;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HI: begin
                if (!s2_q) begin
                    if (SINGLE) begin
                        state_d = ST_LO;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_WAIT_LO: begin
                if (s2_q) begin
                    state_d = ST_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LO;
                level_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs; reset discards any count in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw_level = level_q;
    assign sw_rise  = rise_q;
    assign sw_fall  = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: N_SW independent debounced switch channels plus an OR activity output
module sw_debounce
    import sw_pkg::*;
#(
    parameter int N_SW            = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_32MHZ,
    parameter int CNT_W           = 19
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_in,
    output logic [N_SW-1:0] sw_level,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            sw_any
);

    if (DEBOUNCE_CYCLES < 1 || CNT_W < min_cnt_w(DEBOUNCE_CYCLES)) begin : g_bad_cfg
        $error("sw_debounce: CNT_W too small for DEBOUNCE_CYCLES");
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .sw_in   (sw_in[i]),
            .sw_level(sw_level[i]),
            .sw_rise (sw_rise[i]),
            .sw_fall (sw_fall[i])
        );
    end

    // Levels are registered, so the OR cannot glitch
    assign sw_any = |sw_level;

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: table vectors, corner sequences and random stimulus against a window model
module tb_sw_debounce;

    localparam int N = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sw_in = '0;
    logic [N-1:0] sw_level, sw_rise, sw_fall;
    logic         sw_any;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sw_debounce #(.N_SW(N), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in),
        .sw_level(sw_level),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .sw_any  (sw_any)
    );

    // Model: two-stage delay, then flip level once the last D delayed samples all disagree with it
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_rise = '0, m_fall = '0;
    logic         hist [N][D];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [N-1:0] s);
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
            for (int c = 0; c < N; c++) for (int k = 0; k < D; k++) hist[c][k] = 1'b0;
        end else begin
            for (int c = 0; c < N; c++) begin
                bit all_diff;
                for (int k = D - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = m_s2[c];
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) if (hist[c][k] == m_level[c]) all_diff = 1'b0;
                m_rise[c] = all_diff && !m_level[c];
                m_fall[c] = all_diff && m_level[c];
                if (all_diff) m_level[c] = ~m_level[c];
            end
            m_s2 = m_s1;
            m_s1 = s;
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] s);
        rst   = r;
        sw_in = s;
        @(posedge clk);
        model_edge(r, s);
        #1;
        check("model", {sw_level, sw_rise, sw_fall, sw_any}, {m_level, m_rise, m_fall, |m_level});
    endtask

    typedef struct {
        logic         r;
        logic [N-1:0] sw;
        logic [N-1:0] lvl;
        logic [N-1:0] ri;
        logic [N-1:0] fa;
        logic         any;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int rise_at [N];
        int fall_at [N];
        int n_rise, n_fall, any_drop, bad;
        logic [N-1:0] cur;

        for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0};
        for (int i = 3; i < 8; i++) tbl[i] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[8]  = '{1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1};
        tbl[9]  = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1};
        for (int i = 10; i < 15; i++) tbl[i] = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1};
        tbl[15] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0};
        tbl[16] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].r, tbl[i].sw);
            check($sformatf("vec%0d", i), {sw_level, sw_rise, sw_fall, sw_any},
                  {tbl[i].lvl, tbl[i].ri, tbl[i].fa, tbl[i].any});
        end

        // Clean press on channel 0 only
        rise_at[0] = -1; n_rise = 0; bad = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 2'b01);
            if (sw_rise[0]) begin rise_at[0] = k; n_rise++; end
            if (sw_rise[1] || sw_level[1]) bad++;
        end
        check("press_rise_edge", rise_at[0], 6);
        check("press_rise_count", n_rise, 1);
        check("press_ch1_quiet", bad, 0);
        check("press_level", sw_level, 2'b01);

        // Bounce: 1,0,1,0 then hold 1; final 0->1 is step 5
        for (int k = 0; k < 10; k++) step(1'b0, 2'b00);
        rise_at[0] = -1; n_rise = 0;
        for (int k = 1; k <= 14; k++) begin
            step(1'b0, (k <= 4) ? {1'b0, k[0]} : 2'b01);
            if (sw_rise[0]) begin rise_at[0] = k; n_rise++; end
        end
        check("bounce_rise_edge", rise_at[0], 10);
        check("bounce_rise_count", n_rise, 1);

        // Short glitch: 3 low cycles on a high channel is rejected
        n_fall = 0; bad = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, (k <= 3) ? 2'b00 : 2'b01);
            if (sw_fall[0]) n_fall++;
            if (!sw_level[0]) bad++;
        end
        check("glitch_no_fall", n_fall, 0);
        check("glitch_level_held", bad, 0);

        // Simultaneous rise, then simultaneous fall with sw_any dropping together
        for (int k = 0; k < 10; k++) step(1'b0, 2'b00);
        rise_at = '{-1, -1};
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 2'b11);
            for (int c = 0; c < N; c++) if (sw_rise[c]) rise_at[c] = k;
        end
        fall_at = '{-1, -1}; any_drop = -1;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 2'b00);
            for (int c = 0; c < N; c++) if (sw_fall[c]) fall_at[c] = k;
            if (!sw_any && any_drop < 0) any_drop = k;
        end
        check("simul_rise0", rise_at[0], 6);
        check("simul_rise1", rise_at[1], 6);
        check("simul_fall0", fall_at[0], 6);
        check("simul_fall1", fall_at[1], 6);
        check("simul_any_drop", any_drop, 6);

        // Reset on step 4 discards the count; first non-reset edge is step 5
        rise_at[1] = -1; n_rise = 0;
        for (int k = 1; k <= 14; k++) begin
            step(k == 4, 2'b10);
            if (sw_rise[1]) begin rise_at[1] = k; n_rise++; end
        end
        check("rstmid_rise_edge", rise_at[1], 10);
        check("rstmid_rise_count", n_rise, 1);

        // Random runs of held and bouncing inputs with occasional reset
        cur = '0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 4) == 0) cur = N'($urandom);
            step($urandom_range(0, 299) == 0, cur);
            if ((sw_rise & sw_fall) != '0) check("rise_fall_overlap", sw_rise & sw_fall, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
